// File: rtl/jt9346_dump_pkg.sv
// rtl/jt9346_dump_pkg.sv - shared types and helpers for the jt9346 dump-port bridge
package jt9346_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_RMW_RD,
        ST_RMW_MERGE,
        ST_WR,
        ST_RD,
        ST_RD_WAIT
    } state_t;

    function automatic bit dw_legal(input int dw);
        return (dw == 8) || (dw == 16) || (dw == 32);
    endfunction

    // Bit offset of byte lane 'lane' inside a word of 'nl' lanes.
    function automatic int lane_off(input int lane, input int nl, input bit bigend);
        return (bigend ? (nl - 1 - lane) : lane) * 8;
    endfunction

endpackage

// File: rtl/jt9346_dump_lanes.sv
// rtl/jt9346_dump_lanes.sv - combinational byte insert, masked merge and lane select
//
// word/byte_in/ins_lane -> ins_word : word with byte_in placed into ins_lane
// word/old_word/mask    -> rmw_word : masked lanes from word, the rest from old_word
// sel_word/sel_lane     -> sel_byte : byte of sel_word in sel_lane
module jt9346_dump_lanes
    import jt9346_dump_pkg::*;
#(
    parameter int DW     = 16,
    parameter int LW     = 1,
    parameter bit BIGEND = 1'b0
) (
    input  logic [DW-1:0]   word,
    input  logic [7:0]      byte_in,
    input  logic [LW-1:0]   ins_lane,
    input  logic [DW/8-1:0] mask,
    input  logic [DW-1:0]   old_word,
    input  logic [DW-1:0]   sel_word,
    input  logic [LW-1:0]   sel_lane,
    output logic [DW-1:0]   ins_word,
    output logic [DW-1:0]   rmw_word,
    output logic [7:0]      sel_byte
);

    localparam int NL = DW / 8;

    always_comb begin
        ins_word = word;
        rmw_word = old_word;
        sel_byte = 8'h00;
        for (int i = 0; i < NL; i++) begin
            if (ins_lane == LW'(i)) begin
                ins_word[lane_off(i, NL, BIGEND) +: 8] = byte_in;
            end
            if (mask[i]) begin
                rmw_word[lane_off(i, NL, BIGEND) +: 8] = word[lane_off(i, NL, BIGEND) +: 8];
            end
            if (sel_lane == LW'(i)) begin
                sel_byte = sel_word[lane_off(i, NL, BIGEND) +: 8];
            end
        end
    end

endmodule

// File: rtl/jt9346_dump_bridge.sv
// rtl/jt9346_dump_bridge.sv - byte-wide host dump bus to word-wide jt9346 dump port
//
// Host side : dump_addr/dump_we/dump_rd/dump_din -> dump_dout/dump_ok, busy, lost/lost_clr, flush
// Memory    : mem_req/mem_we/mem_addr/mem_din -> mem_gnt/mem_dout, mem_chg invalidates read buffer
module jt9346_dump_bridge
    import jt9346_dump_pkg::*;
#(
    parameter int AW      = 6,
    parameter int DW      = 16,
    parameter int BL      = $clog2(DW / 8),
    parameter int BIGEND  = 0,
    parameter int PARTIAL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW+BL-1:0] dump_addr,
    input  logic             dump_we,
    input  logic             dump_rd,
    input  logic [7:0]       dump_din,
    output logic [7:0]       dump_dout,
    output logic             dump_ok,
    output logic             busy,
    output logic             lost,
    input  logic             lost_clr,
    input  logic             flush,
    output logic             mem_req,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_din,
    input  logic [DW-1:0]    mem_dout,
    input  logic             mem_gnt,
    input  logic             mem_chg
);

    localparam int NL = DW / 8;
    localparam int LW = (BL > 0) ? BL : 1;
    localparam logic [NL-1:0] FULL = '1;

    if (!dw_legal(DW)) begin : g_bad_dw
        $error("jt9346_dump_bridge: DW must be 8, 16 or 32");
    end

    logic [AW-1:0] req_word;
    logic [LW-1:0] req_lane;

    assign req_word = dump_addr[AW+BL-1:BL];
    if (BL == 0) begin : g_lane0
        assign req_lane = '0;
    end else begin : g_lane
        assign req_lane = dump_addr[BL-1:0];
    end

    state_t        state, state_nx;
    logic [AW-1:0] word_q, word_nx;
    logic [DW-1:0] data_q, data_nx;
    logic [NL-1:0] mask_q, mask_nx;
    logic          hold_v, hold_v_nx, hold_rd, hold_rd_nx;
    logic [AW-1:0] hold_word, hold_word_nx;
    logic [LW-1:0] hold_lane, hold_lane_nx;
    logic [7:0]    hold_din, hold_din_nx;
    logic          buf_v, buf_v_nx;
    logic [AW-1:0] buf_tag, buf_tag_nx;
    logic [DW-1:0] buf_data, buf_data_nx;
    logic [LW-1:0] rd_lane, rd_lane_nx;
    logic [7:0]    dout_nx;
    logic          ok_nx, lost_nx, req_nx, we_nx;
    logic [AW-1:0] addr_nx;
    logic [DW-1:0] din_nx;

    // The only strobe source while in WR is the hold register.
    logic          use_hold;
    logic [AW-1:0] src_word;
    logic [LW-1:0] src_lane;
    logic [7:0]    src_din;
    logic [NL-1:0] lane_bit;
    logic [DW-1:0] ins_word, rmw_word, sel_word;
    logic [LW-1:0] sel_lane;
    logic [7:0]    sel_byte;
    logic          acc, do_start, do_read, wr_inv, hit;

    assign use_hold = (state == ST_WR);
    assign src_word = use_hold ? hold_word : req_word;
    assign src_lane = use_hold ? hold_lane : req_lane;
    assign src_din  = use_hold ? hold_din  : dump_din;
    assign lane_bit = NL'(1) << src_lane;
    assign sel_word = (state == ST_RD_WAIT) ? mem_dout : buf_data;
    assign sel_lane = (state == ST_RD_WAIT) ? rd_lane  : src_lane;
    assign acc      = mem_req & mem_gnt;
    assign busy     = (state != ST_IDLE) && (state != ST_COLLECT);

    jt9346_dump_lanes #(
        .DW     (DW),
        .LW     (LW),
        .BIGEND (BIGEND != 0)
    ) u_lanes (
        .word     (data_q),
        .byte_in  (src_din),
        .ins_lane (src_lane),
        .mask     (mask_q),
        .old_word (mem_dout),
        .sel_word (sel_word),
        .sel_lane (sel_lane),
        .ins_word (ins_word),
        .rmw_word (rmw_word),
        .sel_byte (sel_byte)
    );

    always_comb begin
        state_nx     = state;
        word_nx      = word_q;
        data_nx      = data_q;
        mask_nx      = mask_q;
        hold_v_nx    = hold_v;
        hold_rd_nx   = hold_rd;
        hold_word_nx = hold_word;
        hold_lane_nx = hold_lane;
        hold_din_nx  = hold_din;
        buf_v_nx     = buf_v;
        buf_tag_nx   = buf_tag;
        buf_data_nx  = buf_data;
        rd_lane_nx   = rd_lane;
        dout_nx      = dump_dout;
        ok_nx        = 1'b0;
        req_nx       = acc ? 1'b0 : mem_req;
        we_nx        = mem_we;
        addr_nx      = mem_addr;
        din_nx       = mem_din;
        do_start     = 1'b0;
        do_read      = 1'b0;
        wr_inv       = 1'b0;
        hit          = 1'b0;

        // A write strobe always wins; a simultaneous read is only reported as lost.
        lost_nx = lost_clr ? 1'b0
                : (lost | ((dump_we | dump_rd) & busy) | (dump_we & dump_rd));

        case (state)
            ST_IDLE: begin
                if (dump_we) begin
                    do_start = 1'b1;
                end else if (dump_rd) begin
                    do_read = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (dump_we && (req_word == word_q)) begin
                    data_nx = ins_word;
                    mask_nx = mask_q | lane_bit;
                    if ((mask_q | lane_bit) == FULL) begin
                        req_nx   = 1'b1;
                        we_nx    = 1'b1;
                        addr_nx  = word_q;
                        din_nx   = ins_word;
                        state_nx = ST_WR;
                    end
                end else if (dump_we || dump_rd || flush) begin
                    if (PARTIAL != 0) begin
                        // Park the interrupting strobe and complete the old word first.
                        hold_v_nx    = dump_we | dump_rd;
                        hold_rd_nx   = ~dump_we;
                        hold_word_nx = req_word;
                        hold_lane_nx = req_lane;
                        hold_din_nx  = dump_din;
                        req_nx       = 1'b1;
                        we_nx        = 1'b0;
                        addr_nx      = word_q;
                        state_nx     = ST_RMW_RD;
                    end else begin
                        mask_nx  = '0;
                        state_nx = ST_IDLE;
                        do_start = dump_we;
                        do_read  = dump_rd & ~dump_we;
                    end
                end
            end
            ST_RMW_RD: begin
                if (acc) state_nx = ST_RMW_MERGE;
            end
            ST_RMW_MERGE: begin
                data_nx  = rmw_word;
                req_nx   = 1'b1;
                we_nx    = 1'b1;
                addr_nx  = word_q;
                din_nx   = rmw_word;
                state_nx = ST_WR;
            end
            ST_WR: begin
                if (acc) begin
                    mask_nx  = '0;
                    wr_inv   = (buf_tag == mem_addr);
                    state_nx = ST_IDLE;
                    if (hold_v) begin
                        hold_v_nx = 1'b0;
                        do_start  = ~hold_rd;
                        do_read   = hold_rd;
                    end
                end
            end
            ST_RD: begin
                if (acc) state_nx = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                buf_data_nx = mem_dout;
                buf_tag_nx  = mem_addr;
                buf_v_nx    = 1'b1;
                dout_nx     = sel_byte;
                ok_nx       = 1'b1;
                state_nx    = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase

        if (do_start) begin
            word_nx = src_word;
            data_nx = ins_word;
            mask_nx = lane_bit;
            if (lane_bit == FULL) begin
                req_nx   = 1'b1;
                we_nx    = 1'b1;
                addr_nx  = src_word;
                din_nx   = ins_word;
                state_nx = ST_WR;
            end else begin
                state_nx = ST_COLLECT;
            end
        end

        if (do_read) begin
            // A commit to the buffered word in this very cycle makes the buffer stale.
            hit = buf_v && (buf_tag == src_word) && !wr_inv;
            if (hit) begin
                dout_nx  = sel_byte;
                ok_nx    = 1'b1;
                state_nx = ST_IDLE;
            end else begin
                rd_lane_nx = src_lane;
                req_nx     = 1'b1;
                we_nx      = 1'b0;
                addr_nx    = src_word;
                state_nx   = ST_RD;
            end
        end

        // mem_chg does not cancel a same-cycle hit; it only affects later lookups.
        if (wr_inv || mem_chg) buf_v_nx = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            word_q    <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            hold_v    <= 1'b0;
            hold_rd   <= 1'b0;
            hold_word <= '0;
            hold_lane <= '0;
            hold_din  <= '0;
            buf_v     <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
            rd_lane   <= '0;
            dump_dout <= '0;
            dump_ok   <= 1'b0;
            lost      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
        end else begin
            state     <= state_nx;
            word_q    <= word_nx;
            data_q    <= data_nx;
            mask_q    <= mask_nx;
            hold_v    <= hold_v_nx;
            hold_rd   <= hold_rd_nx;
            hold_word <= hold_word_nx;
            hold_lane <= hold_lane_nx;
            hold_din  <= hold_din_nx;
            buf_v     <= buf_v_nx;
            buf_tag   <= buf_tag_nx;
            buf_data  <= buf_data_nx;
            rd_lane   <= rd_lane_nx;
            dump_dout <= dout_nx;
            dump_ok   <= ok_nx;
            lost      <= lost_nx;
            mem_req   <= req_nx;
            mem_we    <= we_nx;
            mem_addr  <= addr_nx;
            mem_din   <= din_nx;
        end
    end

endmodule

// File: tb/tb_jt9346_dump_bridge.sv
// tb/tb_jt9346_dump_bridge.sv - self-checking bench for jt9346_dump_bridge
module tb_jt9346_dump_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic [7:0] addr = '0;
    logic       we = 1'b0, rd = 1'b0, lost_clr = 1'b0, flush = 1'b0, chg = 1'b0, gnt_en = 1'b1;
    logic [7:0] din = '0;

    // u16: DW=16 little-endian RMW; up: DW=32 little-endian RMW; ud: DW=32 big-endian discard
    logic [7:0]  dout16, doutp, doutd;
    logic        ok16, okp, okd, busy16, busyp, busyd, lost16, lostp, lostd;
    logic        req16, reqp, reqd, mwe16, mwep, mwed;
    logic [5:0]  maddr16, maddrp, maddrd;
    logic [15:0] mdin16, mdout16;
    logic [31:0] mdinp, mdoutp, mdind, mdoutd;

    jt9346_dump_bridge #(.AW(6), .DW(16), .BIGEND(0), .PARTIAL(1)) u16 (
        .clk(clk), .rst_n(rst_n), .dump_addr(addr[6:0]), .dump_we(we), .dump_rd(rd),
        .dump_din(din), .dump_dout(dout16), .dump_ok(ok16), .busy(busy16), .lost(lost16),
        .lost_clr(lost_clr), .flush(flush), .mem_req(req16), .mem_we(mwe16),
        .mem_addr(maddr16), .mem_din(mdin16), .mem_dout(mdout16),
        .mem_gnt(req16 & gnt_en), .mem_chg(chg));

    jt9346_dump_bridge #(.AW(6), .DW(32), .BIGEND(0), .PARTIAL(1)) up (
        .clk(clk), .rst_n(rst_n), .dump_addr(addr), .dump_we(we), .dump_rd(rd),
        .dump_din(din), .dump_dout(doutp), .dump_ok(okp), .busy(busyp), .lost(lostp),
        .lost_clr(lost_clr), .flush(flush), .mem_req(reqp), .mem_we(mwep),
        .mem_addr(maddrp), .mem_din(mdinp), .mem_dout(mdoutp),
        .mem_gnt(reqp & gnt_en), .mem_chg(chg));

    jt9346_dump_bridge #(.AW(6), .DW(32), .BIGEND(1), .PARTIAL(0)) ud (
        .clk(clk), .rst_n(rst_n), .dump_addr(addr), .dump_we(we), .dump_rd(rd),
        .dump_din(din), .dump_dout(doutd), .dump_ok(okd), .busy(busyd), .lost(lostd),
        .lost_clr(lost_clr), .flush(flush), .mem_req(reqd), .mem_we(mwed),
        .mem_addr(maddrd), .mem_din(mdind), .mem_dout(mdoutd),
        .mem_gnt(reqd & gnt_en), .mem_chg(chg));

    logic [15:0] m16 [64];
    logic [31:0] mp  [64];
    logic [31:0] md  [64];
    int wr16 = 0, rd16c = 0, rq16 = 0, wrp = 0, rdp = 0, rqp = 0, wrd = 0, rqd = 0;

    always @(posedge clk) begin
        if (req16) rq16 <= rq16 + 1;
        if (req16 && gnt_en) begin
            if (mwe16) begin m16[maddr16] <= mdin16; wr16 <= wr16 + 1; end
            else begin mdout16 <= m16[maddr16]; rd16c <= rd16c + 1; end
        end
    end
    always @(posedge clk) begin
        if (reqp) rqp <= rqp + 1;
        if (reqp && gnt_en) begin
            if (mwep) begin mp[maddrp] <= mdinp; wrp <= wrp + 1; end
            else begin mdoutp <= mp[maddrp]; rdp <= rdp + 1; end
        end
    end
    always @(posedge clk) begin
        if (reqd) rqd <= rqd + 1;
        if (reqd && gnt_en) begin
            if (mwed) begin md[maddrd] <= mdind; wrd <= wrd + 1; end
            else mdoutd <= md[maddrd];
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy16 | busyp | busyd) && n < 40) begin
            tick();
            n++;
        end
        chk("wait_idle", {busy16, busyp, busyd}, 0);
    endtask

    task automatic do_reset();
        we = 0; rd = 0; lost_clr = 0; flush = 0; chg = 0; gnt_en = 1;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wait_idle();
        addr = a; din = d; we = 1;
        tick();
        we = 0;
    endtask

    task automatic rdb(input logic [7:0] a, output int lat, output logic [7:0] d);
        wait_idle();
        addr = a; rd = 1;
        tick();
        rd = 0;
        lat = 1;
        while (!ok16 && lat < 12) begin
            tick();
            lat++;
        end
        chk("rd_ok_seen", ok16, 1);
        d = dout16;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         lat;
    } rv_t;

    rv_t tbl [8];
    int lat, c0, c1, c2;
    logic [7:0] d;

    initial begin
        tbl[0] = '{8'h00, 8'h34, 3};
        tbl[1] = '{8'h01, 8'h12, 1};
        tbl[2] = '{8'h0C, 8'h78, 3};
        tbl[3] = '{8'h0F, 8'h9A, 3};
        tbl[4] = '{8'h0E, 8'hBC, 1};
        tbl[5] = '{8'h0D, 8'h56, 3};
        tbl[6] = '{8'h03, 8'hBE, 3};
        tbl[7] = '{8'h02, 8'hEF, 1};

        do_reset();
        chk("reset_u16", {dout16, ok16, busy16, lost16, req16, mwe16, maddr16, mdin16}, 0);
        chk("reset_up", {doutp, okp, busyp, lostp, reqp, mwep, maddrp, mdinp}, 0);

        // Preload 32-bit word 1 through the port
        wr(8'h04, 8'hDD); wr(8'h05, 8'hCC); wr(8'h06, 8'hBB); wr(8'h07, 8'hAA);
        wait_idle();
        chk("preload_up_w1", mp[1], 32'hAABBCCDD);
        chk("preload_ud_w1_bigend", md[1], 32'hDDCCBBAA);

        // Two-byte assembly on DW=16, busy only during WR
        wr(8'h00, 8'h34);
        chk("t1_collect_busy", busy16, 0);
        c0 = wr16;
        addr = 8'h01; din = 8'h12; we = 1;
        tick();
        we = 0;
        chk("t1_wr_busy", busy16, 1);
        chk("t1_req", {req16, mwe16, maddr16}, {1'b1, 1'b1, 6'd0});
        chk("t1_din", mdin16, 16'h1234);
        tick();
        chk("t1_after_busy", {busy16, req16}, 0);
        chk("t1_one_write", wr16 - c0, 1);
        chk("t1_mem", m16[0], 16'h1234);

        wr(8'h02, 8'hEF); wr(8'h03, 8'hBE);
        wr(8'h0C, 8'h78); wr(8'h0D, 8'h56); wr(8'h0E, 8'hBC); wr(8'h0F, 8'h9A);
        wait_idle();
        chk("preload_u16_w7", m16[7], 16'h9ABC);

        // Different-word write: RMW (up) versus discard (ud)
        do_reset();
        c0 = wrp; c1 = wrd; c2 = rdp;
        wr(8'h04, 8'h11); wr(8'h08, 8'h77);
        wait_idle();
        chk("t2_rmw_data", mp[1], 32'hAABBCC11);
        chk("t2_rmw_reads", rdp - c2, 1);
        chk("t2_one_write", wrp - c0, 1);
        chk("t3_no_write", wrd - c1, 0);
        chk("t3_w1_kept", md[1], 32'hDDCCBBAA);
        wr(8'h09, 8'h66); wr(8'h0A, 8'h55); wr(8'h0B, 8'h44);
        wait_idle();
        chk("t2_w2", mp[2], 32'h44556677);
        chk("t3_w2_bigend", md[2], 32'h77665544);
        chk("t3_one_write", wrd - c1, 1);

        // Read buffer: miss, hit, mem_chg invalidation
        do_reset();
        c0 = rd16c;
        rdb(8'h02, lat, d);
        chk("t4_miss_lat", lat, 3);
        chk("t4_miss_data", d, 8'hEF);
        tick();
        chk("t4_ok_pulse", ok16, 0);
        rdb(8'h03, lat, d);
        chk("t4_hit_lat", lat, 1);
        chk("t4_hit_data", d, 8'hBE);
        chk("t4_one_access", rd16c - c0, 1);
        chg = 1; tick(); chg = 0;
        rdb(8'h03, lat, d);
        chk("t4_chg_lat", lat, 3);
        chk("t4_chg_access", rd16c - c0, 2);
        // mem_chg coinciding with a hit still returns buffered data
        wait_idle();
        addr = 8'h02; rd = 1; chg = 1;
        tick();
        rd = 0; chg = 0;
        chk("t4_hit_chg_ok", ok16, 1);
        chk("t4_hit_chg_data", dout16, 8'hEF);
        rdb(8'h02, lat, d);
        chk("t4_after_chg_lat", lat, 3);

        for (int i = 0; i < 8; i++) begin
            rdb(tbl[i].a, lat, d);
            chk($sformatf("tbl%0d_data", i), d, tbl[i].d);
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
            tick();
            chk($sformatf("tbl%0d_pulse", i), ok16, 0);
        end

        // WR commit to the buffered word invalidates it
        wr(8'h02, 8'h5A); wr(8'h03, 8'hC3);
        rdb(8'h02, lat, d);
        chk("inv_lat", lat, 3);
        chk("inv_data", d, 8'h5A);

        // Read during collection commits the partial word first
        wr(8'h00, 8'h99);
        rdb(8'h01, lat, d);
        chk("rd_collect_data", d, 8'h12);
        wait_idle();
        chk("rd_collect_mem", m16[0], 16'h1299);

        // flush: ignored in IDLE, RMW (up) or drop (ud) in COLLECT
        do_reset();
        c0 = rq16 + rqp + rqd;
        flush = 1; tick(); flush = 0; tick();
        chk("flush_idle", rq16 + rqp + rqd - c0, 0);
        wr(8'h0C, 8'h5E);
        flush = 1; tick(); flush = 0;
        wait_idle();
        chk("flush_up", mp[3], 32'h9ABC565E);
        chk("flush_ud", md[3], 32'h7856BC9A);

        // Simultaneous write and read: read is lost; lost_clr clears
        do_reset();
        addr = 8'h20; din = 8'h00; we = 1; rd = 1;
        tick();
        we = 0; rd = 0;
        chk("we_rd_lost", lost16, 1);
        lost_clr = 1; tick(); lost_clr = 0;
        chk("lost_clr", lost16, 0);

        // Stalled grant: fields hold, strobes counted lost, clear beats set
        do_reset();
        gnt_en = 0;
        wr(8'h10, 8'h01); wr(8'h11, 8'h02);
        chk("t5_busy", {busy16, req16, mwe16}, 3'b111);
        addr = 8'h12; din = 8'hFF; we = 1;
        tick();
        we = 0;
        chk("t5_lost", lost16, 1);
        repeat (9) tick();
        chk("t5_hold_req", {req16, mwe16, maddr16}, {1'b1, 1'b1, 6'd8});
        chk("t5_hold_din", mdin16, 16'h0201);
        lost_clr = 1; rd = 1;
        tick();
        lost_clr = 0; rd = 0;
        chk("t5_clr_priority", lost16, 0);
        gnt_en = 1;
        wait_idle();
        chk("t5_mem", m16[8], 16'h0201);

        // Reset in RMW_MERGE aborts; nothing issued afterwards
        do_reset();
        c1 = wrp;
        wr(8'h04, 8'h33); wr(8'h08, 8'h22);
        tick();
        chk("t6_in_merge", {busyp, reqp}, 2'b10);
        rst_n = 0;
        #1;
        chk("t6_outputs_zero", {doutp, okp, busyp, lostp, reqp, mwep, maddrp, mdinp}, 0);
        tick();
        rst_n = 1;
        c0 = rqp;
        repeat (10) tick();
        chk("t6_no_req", rqp - c0, 0);
        chk("t6_no_write", wrp - c1, 0);
        chk("t6_mem_kept", mp[1], 32'hAABBCC11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
